// File: rtl/timer_pkg.sv
// Shared definitions for the compare-timer block: register map, arm FSM states
// and CTRL/STATUS bit positions.
package timer_pkg;

  localparam logic [2:0] ADDR_CMP_LO = 3'd0;
  localparam logic [2:0] ADDR_CMP_HI = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_CNT_LO = 3'd5;
  localparam logic [2:0] ADDR_CNT_HI = 3'd6;

  localparam int CTRL_INT_EN_BIT   = 0;
  localparam int CTRL_RELOAD_BIT   = 1;
  localparam int STATUS_INT_ST_BIT = 0;
  localparam int STATUS_STATE_LSB  = 1;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_STAGED   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FIRED    = 2'd3
  } arm_state_t;

endpackage

// File: rtl/timer_cmp_regif.sv
// Register decode for timer_cmp_irq: write strobes, CTRL/staging/PERIOD storage,
// counter snapshot and the registered read port. PERIOD exists only with TIMER_CMP_AUTORELOAD_EN.
module timer_cmp_regif
  import timer_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] count,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  input  logic [2:0]  rd_addr,
  input  logic [63:0] compare,
  input  arm_state_t  state,
  input  logic        int_st,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [31:0] staging_lo,
  output logic        int_en,
`ifdef TIMER_CMP_AUTORELOAD_EN
  output logic        reload_mode,
  output logic [31:0] period,
`endif
  output logic        cmp_lo_wr,
  output logic        cmp_hi_wr,
  output logic        status_w1c
);

  logic [31:0] cnt_hi_shadow;
  logic [31:0] rd_mux;

  assign cmp_lo_wr  = wr_en && (wr_addr == ADDR_CMP_LO);
  assign cmp_hi_wr  = wr_en && (wr_addr == ADDR_CMP_HI);
  assign status_w1c = wr_en && (wr_addr == ADDR_STATUS) && wr_data[STATUS_INT_ST_BIT];

  // NOTE: every output is given a default first so no path through the case infers a latch.
  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      ADDR_CMP_LO: rd_mux = compare[31:0];
      ADDR_CMP_HI: rd_mux = compare[63:32];
      ADDR_CTRL: begin
        rd_mux[CTRL_INT_EN_BIT] = int_en;
`ifdef TIMER_CMP_AUTORELOAD_EN
        rd_mux[CTRL_RELOAD_BIT] = reload_mode;
`endif
      end
      ADDR_STATUS: begin
        rd_mux[STATUS_INT_ST_BIT]         = int_st;
        rd_mux[STATUS_STATE_LSB +: 2]     = state;
      end
`ifdef TIMER_CMP_AUTORELOAD_EN
      ADDR_PERIOD: rd_mux = period;
`endif
      ADDR_CNT_LO: rd_mux = count[31:0];
      ADDR_CNT_HI: rd_mux = cnt_hi_shadow;
      default:     rd_mux = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
  // this is also what makes a same-cycle read return the pre-write register contents.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      staging_lo    <= '0;
      int_en        <= 1'b0;
`ifdef TIMER_CMP_AUTORELOAD_EN
      reload_mode   <= 1'b0;
      period        <= '0;
`endif
      cnt_hi_shadow <= '0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
    end else begin
      if (cmp_lo_wr) staging_lo <= wr_data;
      if (wr_en && (wr_addr == ADDR_CTRL)) begin
        int_en      <= wr_data[CTRL_INT_EN_BIT];
`ifdef TIMER_CMP_AUTORELOAD_EN
        reload_mode <= wr_data[CTRL_RELOAD_BIT];
`endif
      end
`ifdef TIMER_CMP_AUTORELOAD_EN
      if (wr_en && (wr_addr == ADDR_PERIOD)) period <= wr_data;
`endif
      // High word is frozen with the low-word read so a 32-bit reader sees a coherent count.
      if (rd_en && (rd_addr == ADDR_CNT_LO)) cnt_hi_shadow <= count[63:32];
      if (rd_en) rd_data <= rd_mux;
      rd_valid <= rd_en;
    end
  end

endmodule

// File: rtl/timer_cmp_irq.sv
// 64-bit compare timer with staged compare load, arm FSM and level interrupt.
// Define TIMER_CMP_AUTORELOAD_EN to enable periodic reload of the compare value.
module timer_cmp_irq
  import timer_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] count,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        irq
);

  arm_state_t  state, next_state;
  logic [63:0] compare;
  logic [31:0] staging_lo;
  logic        int_st;
  logic        int_en;
  logic        cmp_lo_wr, cmp_hi_wr, status_w1c;
  logic        match;
  logic        fire;
`ifdef TIMER_CMP_AUTORELOAD_EN
  logic        reload_mode;
  logic [31:0] period;
  logic        reload;
`endif

  timer_cmp_regif u_regif (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .count       (count),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .compare     (compare),
    .state       (state),
    .int_st      (int_st),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .staging_lo  (staging_lo),
    .int_en      (int_en),
`ifdef TIMER_CMP_AUTORELOAD_EN
    .reload_mode (reload_mode),
    .period      (period),
`endif
    .cmp_lo_wr   (cmp_lo_wr),
    .cmp_hi_wr   (cmp_hi_wr),
    .status_w1c  (status_w1c)
  );

  assign match = (count >= compare);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_DISARMED;
    else            state <= next_state;
  end

  // Compare-register writes take priority over matching and reload on the same edge.
  always_comb begin
    next_state = state;
    if (cmp_hi_wr)      next_state = ST_ARMED;
    else if (cmp_lo_wr) next_state = ST_STAGED;
    else begin
      case (state)
        ST_ARMED: if (match) next_state = ST_FIRED;
`ifdef TIMER_CMP_AUTORELOAD_EN
        ST_FIRED: if (reload_mode) next_state = ST_ARMED;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    fire = (state == ST_ARMED) && match && !cmp_lo_wr && !cmp_hi_wr;
`ifdef TIMER_CMP_AUTORELOAD_EN
    reload = (state == ST_FIRED) && reload_mode && !cmp_lo_wr && !cmp_hi_wr;
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      compare <= '0;
      int_st  <= 1'b0;
    end else begin
      if (cmp_hi_wr) compare <= {wr_data, staging_lo};
`ifdef TIMER_CMP_AUTORELOAD_EN
      else if (reload) compare <= compare + {32'd0, period};
`endif
      if (fire)            int_st <= 1'b1;
      else if (status_w1c) int_st <= 1'b0;
    end
  end

  assign irq = int_st && int_en;

endmodule
